// File: rtl/timed_value_checker.sv
// timed_value_checker
//
// Reader/checker for a value that a producer writes after a fixed delay. When a
// start is accepted in IDLE, the block waits DELAY cycles in ARM. It then samples
// data_i once in CHECK and compares it against EXP_VAL. It reports the result
// through pass_o/fail_o and a saturating error count.
//
// Timing: start accepted at edge k, data sampled at edge k+DELAY+2, done_o high
// for the cycle that follows edge k+DELAY+3. When start_i is held high, runs
// repeat every DELAY+4 cycles.
//
// Optional feature (macro TIMED_VALUE_CHECKER_PRECHECK_EN):
//   When the macro is defined, data_i is also compared against INIT_VAL on the
//   edge that accepts a start. A mismatch seeds the error count with 1. When the
//   macro is undefined, no precheck logic is built and INIT_VAL is unused.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset; aborts any run in progress
//   start_i      request to begin a run; sampled only in IDLE
//   data_i       monitored value from the producer
//   busy_o       high while a run is in ARM or CHECK
//   done_o       one-cycle pulse when a run completes
//   pass_o       last run had zero errors; held until the next accepted start
//   fail_o       last run had at least one error; held until the next accepted start
//   err_count_o  mismatches in the current or last run; saturates at all-ones
module timed_value_checker #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned DELAY    = 6,
    parameter int unsigned EXP_VAL  = 1,
    parameter int unsigned INIT_VAL = 0,
    parameter int unsigned CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic             fail_o,
    output logic [CNT_W-1:0] err_count_o
);

    // The delay counter needs at least one bit even when DELAY is 0.
    localparam int unsigned CntW = (DELAY == 0) ? 1 : $clog2(DELAY + 1);

    localparam logic [CntW-1:0]  CntInit = CntW'(DELAY);
    localparam logic [WIDTH-1:0] ExpVal  = WIDTH'(EXP_VAL);
    localparam logic [CNT_W-1:0] ErrMax  = '1;
    localparam logic [CNT_W-1:0] ErrOne  = CNT_W'(1);

    typedef enum logic [1:0] {StIdle, StArm, StCheck, StDone} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;
    logic [CNT_W-1:0] pre_err;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == ErrMax) ? v : v + ErrOne;
    endfunction

    // Error count loaded when a start is accepted.
`ifdef TIMED_VALUE_CHECKER_PRECHECK_EN
    localparam logic [WIDTH-1:0] InitVal = WIDTH'(INIT_VAL);
    assign pre_err = (data_i != InitVal) ? ErrOne : '0;
`else
    assign pre_err = '0;
`endif

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_i) state_d = StArm;
            StArm:   if (cnt_q == '0) state_d = StCheck;
            StCheck: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Next values of the datapath and the registered outputs
    always_comb begin
        cnt_d  = cnt_q;
        err_d  = err_q;
        pass_d = pass_q;
        fail_d = fail_q;
        done_d = 1'b0;
        // Derived from the next state so that busy_o is exact despite the register.
        busy_d = (state_d == StArm) || (state_d == StCheck);
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    cnt_d  = CntInit;
                    err_d  = pre_err;
                    pass_d = 1'b0;
                    fail_d = 1'b0;
                end
            end
            StArm: begin
                if (cnt_q != '0) cnt_d = cnt_q - CntW'(1);
            end
            StCheck: begin
                if (data_i != ExpVal) err_d = sat_inc(err_q);
            end
            StDone: begin
                // err_q already includes the CHECK result.
                done_d = 1'b1;
                pass_d = (err_q == '0);
                fail_d = (err_q != '0);
            end
            default: ;
        endcase
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign fail_o      = fail_q;
    assign err_count_o = err_q;

endmodule

// File: tb/tb_timed_value_checker.sv
// Bench for timed_value_checker. Two instances share one stimulus stream:
// u_dut0 (DELAY=6, CNT_W=4) and u_dut1 (DELAY=0, CNT_W=1).
// Each completed run is scored through a queue of expected results. Held outputs
// are compared on every edge.
module tb_timed_value_checker;

    localparam int T     = 600;
    localparam int EXP   = 1;
    localparam int INITV = 0;

    logic       clk = 1'b1;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] data = 4'd0;

    logic       busy0, done0, pass0, fail0;
    logic [3:0] err0;
    logic       busy1, done1, pass1, fail1;
    logic [0:0] err1;

    timed_value_checker #(
        .WIDTH(4), .DELAY(6), .EXP_VAL(EXP), .INIT_VAL(INITV), .CNT_W(4)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start_i(start), .data_i(data),
        .busy_o(busy0), .done_o(done0), .pass_o(pass0), .fail_o(fail0),
        .err_count_o(err0)
    );

    timed_value_checker #(
        .WIDTH(4), .DELAY(0), .EXP_VAL(EXP), .INIT_VAL(INITV), .CNT_W(1)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start_i(start), .data_i(data),
        .busy_o(busy1), .done_o(done1), .pass_o(pass1), .fail_o(fail1),
        .err_count_o(err1)
    );

    always #5 clk = ~clk;

    typedef struct {
        int t;
        int err;
        int pass;
        int fail;
    } res_t;

    res_t q0[$];
    res_t q1[$];

    bit         s_rst[T];  // rst_n level before edge t
    bit         s_st[T];
    logic [3:0] s_dat[T];

    int dly[2];
    int cmax[2];
    int m_act[2], m_k[2], m_err[2], m_pass[2], m_fail[2];
    int e_busy[2][T], e_pass[2][T], e_fail[2][T], e_err[2][T];

    int errors = 0;
    int checks = 0;

    task automatic cmp(input string name, input int t, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s edge=%0d got=%0d want=%0d", name, t, act, exp);
        end
    endtask

    function automatic int pre_err(input int k);
`ifdef TIMED_VALUE_CHECKER_PRECHECK_EN
        return (s_dat[k] != 4'(INITV)) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    // Final error count of a run accepted at edge k on instance i.
    function automatic int run_err(input int i, input int k);
        int e;
        e = pre_err(k);
        if (s_dat[k + dly[i] + 2] != 4'(EXP)) e = (e + 1 > cmax[i]) ? cmax[i] : e + 1;
        return e;
    endfunction

    // A run is lost if reset hits any edge up to its done edge, or if it cannot finish in time.
    function automatic bit lost(input int i, input int k);
        for (int u = k + 1; u <= k + dly[i] + 3; u++) begin
            if (u >= T) return 1'b1;
            if (!s_rst[u]) return 1'b0 | 1'b1;
        end
        return 1'b0;
    endfunction

    // Spec-level model: a run accepted at k is busy for edges k..k+D+1 and
    // ends with DONE at k+D+3.
    task automatic model_step(input int t);
        res_t r;
        int   busy;
        int   ph;
        for (int i = 0; i < 2; i++) begin
            busy = 0;
            if (!s_rst[t]) begin
                m_act[i] = 0; m_err[i] = 0; m_pass[i] = 0; m_fail[i] = 0;
            end else if (m_act[i] != 0) begin
                ph = t - m_k[i];
                if (ph == dly[i] + 2) begin
                    m_err[i] = run_err(i, m_k[i]);
                end else if (ph == dly[i] + 3) begin
                    m_pass[i] = (m_err[i] == 0) ? 1 : 0;
                    m_fail[i] = 1 - m_pass[i];
                    m_act[i]  = 0;
                end else begin
                    busy = 1;
                end
            end else if (s_st[t]) begin
                m_act[i] = 1; m_k[i] = t; m_err[i] = pre_err(t);
                m_pass[i] = 0; m_fail[i] = 0; busy = 1;
                if (!lost(i, t)) begin
                    r.t    = t + dly[i] + 3;
                    r.err  = run_err(i, t);
                    r.pass = (r.err == 0) ? 1 : 0;
                    r.fail = (r.err != 0) ? 1 : 0;
                    if (i == 0) q0.push_back(r);
                    else q1.push_back(r);
                end
            end
            e_busy[i][t] = busy;
            e_pass[i][t] = m_pass[i];
            e_fail[i][t] = m_fail[i];
            e_err[i][t]  = m_err[i];
        end
    endtask

    task automatic check_edge(input int i, input int t, input logic b, input logic d,
                              input logic p, input logic f, input int e);
        res_t r;
        int   have;
        cmp($sformatf("dut%0d.busy", i), t, int'(b), e_busy[i][t]);
        cmp($sformatf("dut%0d.pass", i), t, int'(p), e_pass[i][t]);
        cmp($sformatf("dut%0d.fail", i), t, int'(f), e_fail[i][t]);
        cmp($sformatf("dut%0d.err_count", i), t, e, e_err[i][t]);
        have = (i == 0) ? q0.size() : q1.size();
        if (have > 0) r = (i == 0) ? q0[0] : q1[0];
        if (d) begin
            if (have == 0) begin
                cmp($sformatf("dut%0d.unexpected_done", i), t, int'(d), 0);
            end else begin
                if (i == 0) void'(q0.pop_front());
                else void'(q1.pop_front());
                cmp($sformatf("dut%0d.done_edge", i), t, t, r.t);
                cmp($sformatf("dut%0d.run_err", i), t, e, r.err);
                cmp($sformatf("dut%0d.run_pass", i), t, int'(p), r.pass);
                cmp($sformatf("dut%0d.run_fail", i), t, int'(f), r.fail);
            end
        end else if (have > 0 && r.t <= t) begin
            cmp($sformatf("dut%0d.missing_done", i), t, int'(d), 1);
            if (i == 0) void'(q0.pop_front());
            else void'(q1.pop_front());
        end
    endtask

    // Monitor: compare outputs 1 time unit after each active edge
    initial begin
        @(negedge clk);
        for (int t = 0; t < T; t++) begin
            @(posedge clk);
            #1;
            check_edge(0, t, busy0, done0, pass0, fail0, int'(err0));
            check_edge(1, t, busy1, done1, pass1, fail1, int'(err1));
        end
    end

    // Stimulus and model
    initial begin
        dly[0] = 6; cmax[0] = 15;
        dly[1] = 0; cmax[1] = 1;
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 0; m_k[i] = 0; m_err[i] = 0; m_pass[i] = 0; m_fail[i] = 0;
        end
        for (int t = 0; t < T; t++) begin
            s_rst[t] = 1'b1; s_st[t] = 1'b0; s_dat[t] = 4'd0;
        end
        // Reset held for three edges, with start high throughout
        for (int t = 0; t < 3; t++) begin
            s_rst[t] = 1'b0; s_st[t] = 1'b1; s_dat[t] = 4'($urandom);
        end
        // Nominal run: start at 10; producer writes 1 from 15
        s_st[10] = 1'b1;
        for (int t = 15; t <= 20; t++) s_dat[t] = 4'd1;
        // Late producer: start at 30; data stays 0 until 40; then idle cycles
        s_st[30] = 1'b1;
        for (int t = 40; t <= 49; t++) s_dat[t] = 4'd1;
        // Second start during ARM is ignored
        s_st[50] = 1'b1; s_st[53] = 1'b1;
        for (int t = 50; t <= 69; t++) s_dat[t] = 4'd1;
        // Reset during ARM aborts the run
        s_st[62] = 1'b1; s_rst[65] = 1'b0; s_rst[66] = 1'b0;
        // Error at start (precheck) and at check
        s_st[70] = 1'b1; s_dat[70] = 4'd3;
        // Start held high: back-to-back runs
        for (int t = 82; t <= 93; t++) s_st[t] = 1'b1;
        for (int t = 82; t <= 109; t++) s_dat[t] = 4'd1;
        // Randomized region
        for (int t = 110; t < T - 12; t++) begin
            s_st[t]  = ($urandom_range(0, 2) == 0);
            s_dat[t] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'(EXP);
            s_rst[t] = ($urandom_range(0, 79) != 0);
        end
        for (int t = T - 12; t < T; t++) s_dat[t] = 4'($urandom);

        for (int t = 0; t < T; t++) begin
            @(negedge clk);
            rst_n = s_rst[t];
            start = s_st[t];
            data  = s_dat[t];
            model_step(t);
            // Reset must clear the outputs before the next clock edge
            if (t > 0 && !s_rst[t] && s_rst[t - 1]) begin
                #1;
                cmp("async_rst.busy0", t, int'(busy0), 0);
                cmp("async_rst.busy1", t, int'(busy1), 0);
                cmp("async_rst.done0", t, int'(done0), 0);
                cmp("async_rst.err0", t, int'(err0), 0);
                cmp("async_rst.pass_fail0", t, int'(pass0) + int'(fail0), 0);
            end
        end
        @(posedge clk);
        #3;
        cmp("dut0.pending_runs", T, q0.size(), 0);
        cmp("dut1.pending_runs", T, q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
